// File: rtl/vga_sync_if.sv
// Raster timing bundle shared by the sync generator and the renderers.
interface vga_sync_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_en;
    logic       frame_start;

    modport master (
        output hcount, vcount, hsync, vsync,
        output video_on, pix_en, frame_start
    );

    modport slave (
        input hcount, vcount, hsync, vsync,
        input video_on, pix_en, frame_start
    );
endinterface

// File: rtl/vga_sync.sv
// Raster timing generator: pixel-rate divider, h/v counters, sync decodes.
module vga_sync #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync: H_TOTAL/V_TOTAL exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
        $error("vga_sync: CLK_DIV must be 1..4");
    end

    localparam logic [1:0]  DIV_MAX = 2'(CLK_DIV - 1);
    localparam logic [9:0]  H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [10:0] HA      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_B    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_E    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VA      = 11'(V_ACTIVE);
    localparam logic [10:0] VS_B    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_E    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0] div_q, div_d;
    logic       pix_q, pix_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       von_q, von_d;
    logic       fs_q, fs_d;

    logic [10:0] h_x;
    logic [10:0] v_x;

    always_comb begin
        div_d = (div_q == DIV_MAX) ? 2'd0 : div_q + 2'd1;
        pix_d = (div_q == DIV_MAX);
        h_d   = h_q;
        v_d   = v_q;
        if (pix_q) begin
            if (h_q == H_MAX) begin
                h_d = 10'd0;
                v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        fs_d  = pix_q && (h_q == H_MAX) && (v_q == V_MAX);
        // Decode from next-state counts so flags line up with the counters.
        h_x   = {1'b0, h_d};
        v_x   = {1'b0, v_d};
        hs_d  = !((h_x >= HS_B) && (h_x < HS_E));
        vs_d  = !((v_x >= VS_B) && (v_x < VS_E));
        von_d = (h_x < HA) && (v_x < VA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 2'd0;
            pix_q <= 1'b0;
            h_q   <= 10'd0;
            v_q   <= 10'd0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            von_q <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            pix_q <= pix_d;
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
            fs_q  <= fs_d;
        end
    end

    assign vga.hcount      = h_q;
    assign vga.vcount      = v_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.video_on    = von_q;
    assign vga.pix_en      = pix_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: default timing for line checks, a reduced raster for
// frame/vsync/reset checks, and a CLK_DIV=1 build of the reduced raster.
module tb_vga_sync;
    logic clk;
    logic rstd, rsts, rst1;

    vga_sync_if vifd ();
    vga_sync_if vifs ();
    vga_sync_if vif1 ();

    vga_sync dutd (.clk(clk), .rst(rstd), .vga(vifd));

    vga_sync #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) duts (.clk(clk), .rst(rsts), .vga(vifs));

    vga_sync #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dut1 (.clk(clk), .rst(rst1), .vga(vif1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hsd_low, hss_low, vss_low, vons_hi, fss_n;
    int vs1_low, fs1_n, pix1_lo;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hsd_low = 0; hss_low = 0; vss_low = 0; vons_hi = 0;
        fss_n = 0; vs1_low = 0; fs1_n = 0; pix1_lo = 0;
    endtask

    task automatic go(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
            if (!vifd.hsync) hsd_low++;
            if (!vifs.hsync) hss_low++;
            if (!vifs.vsync) vss_low++;
            if (vifs.video_on) vons_hi++;
            if (vifs.frame_start) fss_n++;
            if (!vif1.vsync) vs1_low++;
            if (vif1.frame_start) fs1_n++;
            if (!vif1.pix_en) pix1_lo++;
        end
    endtask

    initial begin
        rstd = 1'b1; rsts = 1'b1; rst1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstd = 1'b0; cyc = 0; clr();

        // default timing: reset state and first line
        chk("rst_h", 32'(vifd.hcount), 0);
        chk("rst_v", 32'(vifd.vcount), 0);
        chk("rst_hs", 32'(vifd.hsync), 1);
        chk("rst_vs", 32'(vifd.vsync), 1);
        chk("rst_von", 32'(vifd.video_on), 1);
        chk("rst_fs", 32'(vifd.frame_start), 0);
        chk("rst_pix", 32'(vifd.pix_en), 0);
        go(1);    chk("pix_c1", 32'(vifd.pix_en), 0);
        go(2);    chk("pix_c2", 32'(vifd.pix_en), 1);
        go(3);    chk("h_first", 32'(vifd.hcount), 1);
        go(1279); chk("von_639", 32'(vifd.video_on), 1);
        go(1281); chk("h_640", 32'(vifd.hcount), 640);
                  chk("von_640", 32'(vifd.video_on), 0);
        go(1311); chk("hs_655", 32'(vifd.hsync), 1);
        go(1313); chk("h_656", 32'(vifd.hcount), 656);
                  chk("hs_656", 32'(vifd.hsync), 0);
        go(1504); chk("hs_751", 32'(vifd.hsync), 0);
        go(1505); chk("hs_752", 32'(vifd.hsync), 1);
        go(1600); chk("h_799", 32'(vifd.hcount), 799);
                  chk("v_799", 32'(vifd.vcount), 0);
        go(1601); chk("h_wrap", 32'(vifd.hcount), 0);
                  chk("v_wrap", 32'(vifd.vcount), 1);
        chk("hs_low_len", 32'(hsd_low), 192);

        // reduced raster 32x18, CLK_DIV=2
        rsts = 1'b0; cyc = 0; clr();
        chk("s_rst_fs", 32'(vifs.frame_start), 0);
        chk("s_rst_h", 32'(vifs.hcount), 0);
        go(2);    chk("s_pix", 32'(vifs.pix_en), 1);
        go(65);   chk("s_hwrap", 32'(vifs.hcount), 0);
                  chk("s_vinc", 32'(vifs.vcount), 1);
        go(641);  chk("s_v10", 32'(vifs.vcount), 10);
                  chk("s_von_v10", 32'(vifs.video_on), 0);
        go(768);  chk("s_vs_pre", 32'(vifs.vsync), 1);
        go(769);  chk("s_vs_fall", 32'(vifs.vsync), 0);
                  chk("s_vs_h", 32'(vifs.hcount), 0);
                  chk("s_vs_v", 32'(vifs.vcount), 12);
        go(896);  chk("s_vs_last", 32'(vifs.vsync), 0);
        go(897);  chk("s_vs_rise", 32'(vifs.vsync), 1);
                  chk("s_vs_rv", 32'(vifs.vcount), 14);
        go(1152); chk("s_fs_pre", 32'(vifs.frame_start), 0);
        chk("s_fs_none", 32'(fss_n), 0);
        chk("s_vs_len", 32'(vss_low), 128);
        chk("s_von_cnt", 32'(vons_hi), 320);
        chk("s_hs_cnt", 32'(hss_low), 216);
        go(1153); chk("s_fs1", 32'(vifs.frame_start), 1);
                  chk("s_fs1_h", 32'(vifs.hcount), 0);
                  chk("s_fs1_v", 32'(vifs.vcount), 0);
        go(1154); chk("s_fs1_end", 32'(vifs.frame_start), 0);
        go(2304); chk("s_fs2_pre", 32'(vifs.frame_start), 0);
        go(2305); chk("s_fs2", 32'(vifs.frame_start), 1);
        go(3457); chk("s_fs3", 32'(vifs.frame_start), 1);
        chk("s_fs_cnt", 32'(fss_n), 3);

        // reset during the vsync pulse
        go(4229); chk("s_mid_vs", 32'(vifs.vsync), 0);
                  chk("s_mid_v", 32'(vifs.vcount), 12);
        rsts = 1'b1;
        @(negedge clk);
        rsts = 1'b0; cyc = 0;
        chk("s_mr_vs", 32'(vifs.vsync), 1);
        chk("s_mr_h", 32'(vifs.hcount), 0);
        chk("s_mr_v", 32'(vifs.vcount), 0);
        chk("s_mr_pix", 32'(vifs.pix_en), 0);
        chk("s_mr_fs", 32'(vifs.frame_start), 0);
        go(1);    chk("s_mr_pix1", 32'(vifs.pix_en), 0);
        go(2);    chk("s_mr_pix2", 32'(vifs.pix_en), 1);
        go(3);    chk("s_mr_h1", 32'(vifs.hcount), 1);
        go(65);   chk("s_mr_wrap", 32'(vifs.vcount), 1);

        // CLK_DIV=1 build
        rst1 = 1'b0; cyc = 0; clr();
        chk("d1_rst_pix", 32'(vif1.pix_en), 0);
        go(1);    chk("d1_pix", 32'(vif1.pix_en), 1);
                  chk("d1_h0", 32'(vif1.hcount), 0);
        go(33);   chk("d1_hwrap", 32'(vif1.hcount), 0);
                  chk("d1_vinc", 32'(vif1.vcount), 1);
        go(384);  chk("d1_vs_pre", 32'(vif1.vsync), 1);
        go(385);  chk("d1_vs_fall", 32'(vif1.vsync), 0);
                  chk("d1_vs_v", 32'(vif1.vcount), 12);
        go(449);  chk("d1_vs_rise", 32'(vif1.vsync), 1);
        go(576);  chk("d1_fs_pre", 32'(vif1.frame_start), 0);
        chk("d1_vs_len", 32'(vs1_low), 64);
        chk("d1_fs_none", 32'(fs1_n), 0);
        go(577);  chk("d1_fs1", 32'(vif1.frame_start), 1);
                  chk("d1_fs1_v", 32'(vif1.vcount), 0);
        go(1153); chk("d1_fs2", 32'(vif1.frame_start), 1);
        chk("d1_fs_cnt", 32'(fs1_n), 2);
        chk("d1_pix_lo", 32'(pix1_lo), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_sync.md
# vga_sync

Raster timing generator for the Pong display pipeline. From the single system clock it derives a pixel-rate enable and runs 10-bit horizontal and vertical counters. It produces `hcount`, `vcount`, active-low `hsync`/`vsync`, a `video_on` blanking flag and a one-cycle `frame_start` pulse. These outputs feed the paddle, ball and score renderers directly. The renderers update their object positions on the falling edge of `vsync`.

## Interface

Parameters:
- `CLK_DIV`, 2: number of `clk` cycles per pixel (2 gives 25 MHz pixels from 50 MHz); legal range 1..4.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `hcount` output 10: current pixel column, 0..H_TOTAL-1.
- `vcount` output 10: current line, 0..V_TOTAL-1.
- `hsync` output 1: horizontal sync, active low.
- `vsync` output 1: vertical sync, active low.
- `video_on` output 1: high when hcount < H_ACTIVE and vcount < V_ACTIVE.
- `pix_en` output 1: one-`clk` pulse marking the last `clk` of each pixel.
- `frame_start` output 1: one-`clk` pulse on entry to pixel (0,0).

## Operation

- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
  - Both totals must be ≤ 1024. Elaboration fails otherwise.
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = 1 when `div_cnt` == CLK_DIV-1.
  - With CLK_DIV=1, `pix_en` is constantly 1 outside reset.
- Counters:
  - On a `clk` edge with `pix_en`=1, `hcount` increments.
  - When `hcount` == H_TOTAL-1, `hcount` wraps to 0 and `vcount` increments.
  - When `vcount` == V_TOTAL-1 at that same wrap, `vcount` wraps to 0.
  - Counters are unsigned 10-bit, and no value ≥ TOTAL is ever produced.
  - Counters hold their value whenever `pix_en`=0.
- Decodes (registered, so they change in the same cycle as the counters they describe):
  - `hsync` = 0 iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - `vsync` = 0 iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
  - `vsync` therefore falls on the `clk` edge where `hcount` wraps and `vcount` moves from 489 to 490, and it rises when `vcount` moves from 491 to 492.
  - `frame_start` = 1 for exactly one `clk`: the cycle in which the counters first show (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
- Reset (`rst`=1 at an edge):
  - div_cnt=0, hcount=0, vcount=0.
  - hsync=1, vsync=1, video_on=1.
  - pix_en=0, frame_start=0.
  - Reset takes priority over everything, including mid-line, mid-sync-pulse and the wrap cycle.
  - Leaving reset does not generate a `frame_start`. The first pulse comes after one full frame.

## Timing

- The first `pix_en` occurs CLK_DIV `clk` cycles after the cycle in which `rst` is deasserted.
- `hcount` advances one `clk` after each `pix_en`. A line lasts H_TOTAL×CLK_DIV `clk` cycles (1600 by default).
- A frame lasts H_TOTAL×V_TOTAL×CLK_DIV `clk` cycles (840000 by default).
- The `vsync` low pulse lasts V_SYNC×H_TOTAL×CLK_DIV `clk` cycles (3200 by default).
- The `hsync` low pulse lasts H_SYNC×CLK_DIV `clk` cycles (192 by default).
- Outputs carry no extra latency relative to the counters. Downstream renderers register their pixel outputs once, so they lag `hcount` by one `clk`. Within a pixel of CLK_DIV `clk` cycles this is acceptable and is not compensated here.

## Test plan

- Reset defaults:
  - Stimulus: hold `rst` for 3 cycles, then release.
  - Response: hcount=0, vcount=0, hsync=1, vsync=1, video_on=1, frame_start=0; first `pix_en` exactly 2 `clk` after release.
- Horizontal wrap:
  - Stimulus: run one line with defaults.
  - Response: hcount goes 799→0 and vcount goes 0→1 on the same edge, 1600 `clk` after reset release; `video_on` falls at hcount=640; `hsync` is low for hcount 656..751 (192 `clk`).
- Vertical sync:
  - Stimulus: run one frame.
  - Response: `vsync` falls when vcount reaches 490 with hcount=0, stays low for exactly 3200 `clk`, and rises at vcount=492; `video_on` is 0 for all vcount ≥ 480.
- Frame period:
  - Stimulus: run 3 frames.
  - Response: `frame_start` pulses are exactly 840000 `clk` apart, each 1 `clk` wide, coinciding with hcount=0 and vcount=0; no pulse at reset release.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while vcount=490 (vsync low).
  - Response: next cycle shows vsync=1, hcount=0, vcount=0; timing then matches the reset-defaults scenario.
- CLK_DIV=1 build:
  - Stimulus: run one frame.
  - Response: `pix_en` is constant 1, the line is 800 `clk`, the frame is 420000 `clk`, and the vsync low pulse is 1600 `clk`.
